load_store_unit: RTL and testbench

Memory stage of the RV32I core, directly downstream of the execute stage. It takes the execute result (effective address, or the plain ALU result for non-memory ops) plus rs2 store data, runs one data-memory transaction over a req/gnt/rvalid handshake, and hands the load-aligned or passed-through result to writeback under a valid/ready handshake. It is a multi-cycle unit that accepts one operation at a time.

---
 rtl/load_store_unit_pkg.sv | 26 ++
 rtl/load_store_unit_align.sv | 69 ++++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared opcode/funct3 encodings and FSM state type for the load/store unit.
// No logic; constants and types only.
// Imported by the LSU top and its alignment helper.
package load_store_unit_pkg;

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] FUNCT3_LB  = 3'd0;
   localparam logic [2:0] FUNCT3_LH  = 3'd1;
   localparam logic [2:0] FUNCT3_LW  = 3'd2;
   localparam logic [2:0] FUNCT3_LBU = 3'd4;
   localparam logic [2:0] FUNCT3_LHU = 3'd5;

   localparam logic [2:0] FUNCT3_SB  = 3'd0;
   localparam logic [2:0] FUNCT3_SH  = 3'd1;
   localparam logic [2:0] FUNCT3_SW  = 3'd2;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the LSU: store enables/replicated data, fault flag, load extract/extend.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are sampled.
module load_store_unit_align
   import load_store_unit_pkg::*;
(
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        fault_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store lane enables and replicated data; misalignment and unsupported widths fault
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = store_data_i;
      fault_o = 1'b0;
      if (is_store_i) begin
         case (funct3_i)
            FUNCT3_SB: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{store_data_i[7:0]}};
            end
            FUNCT3_SH: begin
               be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
               wdata_o = {2{store_data_i[15:0]}};
               fault_o = addr_lo_i[0];
            end
            FUNCT3_SW: fault_o = |addr_lo_i;
            default:   fault_o = 1'b1;
         endcase
      end else if (is_load_i) begin
         case (funct3_i)
            FUNCT3_LB, FUNCT3_LBU: fault_o = 1'b0;
            FUNCT3_LH, FUNCT3_LHU: fault_o = addr_lo_i[0];
            FUNCT3_LW:             fault_o = |addr_lo_i;
            default:               fault_o = 1'b1;
         endcase
      end
   end

   // Pick the addressed byte/half from the returned word and extend it per funct3
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         FUNCT3_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
         FUNCT3_LBU: load_data_o = {24'd0, byte_sel};
         FUNCT3_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
         FUNCT3_LHU: load_data_o = {16'd0, half_sel};
         default:    load_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store (or ALU pass-through) per operation via req/gnt/rvalid.
// Latency: 1 cycle for non-memory/faulting ops, 2+ for stores, 3+ for loads.
// Accepts only in IDLE; holds the result in DONE until writeback raises ready_i.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] store_data_i,
   input  logic [4:0]        rd_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] result_o,
   output logic [4:0]        rd_o,
   output logic              fault_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DWIDTH-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DWIDTH-1:0] mem_rdata_i
);

   lsu_state_e        state_q;
   logic [2:0]        funct3_q;
   logic [1:0]        addr_lo_q;
   logic [4:0]        rd_q;
   logic              valid_q;
   logic              fault_q;
   logic [DWIDTH-1:0] result_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [AWIDTH-1:0] mem_addr_q;
   logic [3:0]        mem_be_q;
   logic [DWIDTH-1:0] mem_wdata_q;

   logic              in_idle;
   logic              is_load;
   logic              is_store;
   logic [2:0]        al_funct3;
   logic [1:0]        al_addr_lo;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata;
   logic              al_fault;
   logic [31:0]       al_load;

   assign in_idle  = (state_q == LSU_IDLE);
   assign is_load  = (opcode_i == OPCODE_LOAD);
   assign is_store = (opcode_i == OPCODE_STORE);

   // In IDLE the helper decodes the incoming op; afterwards it extracts from the captured op
   assign al_funct3  = in_idle ? funct3_i : funct3_q;
   assign al_addr_lo = in_idle ? addr_i[1:0] : addr_lo_q;

   load_store_unit_align u_align (
      .is_load_i    (is_load),
      .is_store_i   (is_store),
      .funct3_i     (al_funct3),
      .addr_lo_i    (al_addr_lo),
      .store_data_i (store_data_i),
      .rdata_i      (mem_rdata_i),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .fault_o      (al_fault),
      .load_data_o  (al_load)
   );

   // Single FSM: accept, issue request, wait for data, present result; all outputs registered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= LSU_IDLE;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         rd_q        <= '0;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
         result_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (valid_i) begin
                  funct3_q  <= funct3_i;
                  addr_lo_q <= addr_i[1:0];
                  rd_q      <= rd_i;
                  if ((is_load || is_store) && !al_fault) begin
                     state_q     <= LSU_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= is_store;
                     mem_addr_q  <= {addr_i[AWIDTH-1:2], 2'b00};
                     mem_be_q    <= al_be;
                     mem_wdata_q <= is_store ? al_wdata : '0;
                     result_q    <= '0;
                     fault_q     <= 1'b0;
                  end else begin
                     // Non-memory ops forward the ALU result; faults report zero
                     state_q  <= LSU_DONE;
                     valid_q  <= 1'b1;
                     fault_q  <= al_fault;
                     result_q <= (is_load || is_store) ? '0 : DWIDTH'(addr_i);
                  end
               end
            end
            LSU_REQ: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  if (mem_we_q) begin
                     state_q <= LSU_DONE;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= LSU_WAIT;
                  end
               end
            end
            LSU_WAIT: begin
               if (mem_rvalid_i) begin
                  result_q <= al_load;
                  valid_q  <= 1'b1;
                  state_q  <= LSU_DONE;
               end
            end
            LSU_DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= LSU_IDLE;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

   assign ready_o     = in_idle;
   assign valid_o     = valid_q;
   assign result_o    = result_q;
   assign rd_o        = rd_q;
   assign fault_o     = fault_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops against a reference model.
// Memory side is driven by the bench with chosen grant/rvalid delays.
// Writeback backpressure is exercised by holding ready_i low.
module tb_load_store_unit;

   logic        clk;
   logic        reset_n;
   logic        valid_i;
   logic        ready_o;
   logic [6:0]  opcode_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic [4:0]  rd_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        fault_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int tests = 0;
   int fails = 0;

   load_store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .opcode_i     (opcode_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .store_data_i (store_data_i),
      .rd_i         (rd_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .result_o     (result_o),
      .rd_o         (rd_o),
      .fault_o      (fault_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   typedef struct packed {
      logic        is_mem;
      logic        we;
      logic        fault;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] result;
   } exp_t;

   // Reference model: access size in bytes, alignment by modulo, lane masks by arithmetic
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] word);
      exp_t        e;
      int          off;
      int          size;
      logic [31:0] mask;
      logic [31:0] v;
      off      = int'(addr % 4);
      e.is_mem = (op == OP_LOAD) || (op == OP_STORE);
      e.we     = (op == OP_STORE);
      e.fault  = 1'b0;
      e.be     = 4'hF;
      e.wdata  = sd;
      e.result = 32'd0;
      if (!e.is_mem) begin
         e.result = addr;
         return e;
      end
      if (e.we) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
      else      size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
      if (size == 0 || (off % size) != 0) begin
         e.fault = 1'b1;
         return e;
      end
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (e.we) begin
         e.be    = 4'(((32'd1 << size) - 32'd1) << off);
         e.wdata = (size == 1) ? (sd & mask) * 32'h0101_0101 :
                   (size == 2) ? (sd & mask) * 32'h0001_0001 : sd;
      end else begin
         v = (word >> (8 * off)) & mask;
         if ((f3 == 0 || f3 == 1) && v[8 * size - 1]) v = v | ~mask;
         e.result = v;
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_ready"},  ready_o,     32'd1);
      chk({pfx, "_valid"},  valid_o,     32'd0);
      chk({pfx, "_fault"},  fault_o,     32'd0);
      chk({pfx, "_req"},    mem_req_o,   32'd0);
      chk({pfx, "_we"},     mem_we_o,    32'd0);
      chk({pfx, "_result"}, result_o,    32'd0);
      chk({pfx, "_rd"},     rd_o,        32'd0);
      chk({pfx, "_maddr"},  mem_addr_o,  32'd0);
      chk({pfx, "_be"},     mem_be_o,    32'd0);
      chk({pfx, "_wdata"},  mem_wdata_o, 32'd0);
   endtask

   // One complete operation: accept, memory handshake with given delays, writeback with hold cycles
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rdv, input int gd,
                         input int rvd, input logic [31:0] word, input int hold,
                         input logic glitch);
      exp_t        e;
      logic [31:0] waddr;
      e     = model(op, f3, addr, sd, word);
      waddr = {addr[31:2], 2'b00};
      chk("accept_ready", ready_o, 32'd1);
      valid_i      = 1'b1;
      opcode_i     = op;
      funct3_i     = f3;
      addr_i       = addr;
      store_data_i = sd;
      rd_i         = rdv;
      step();
      // scramble inputs so the DUT must rely on captured values
      valid_i      = 1'b0;
      opcode_i     = 7'($urandom);
      funct3_i     = 3'($urandom);
      addr_i       = $urandom;
      store_data_i = $urandom;
      rd_i         = 5'($urandom);
      if (e.is_mem && !e.fault) begin
         chk("req",        mem_req_o,  32'd1);
         chk("we",         mem_we_o,   32'(e.we));
         chk("maddr",      mem_addr_o, waddr);
         chk("be",         mem_be_o,   32'(e.be));
         if (e.we) chk("wdata", mem_wdata_o, e.wdata);
         chk("busy_ready", ready_o,    32'd0);
         for (int i = 0; i < gd; i++) begin
            step();
            chk("req_hold", 32'(mem_req_o && !valid_o && mem_addr_o == waddr && mem_be_o == e.be
                                && mem_we_o == e.we && (!e.we || mem_wdata_o == e.wdata)), 32'd1);
         end
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = glitch;
         mem_rdata_i  = ~word;
         step();
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (!e.we) begin
            chk("req_drop",   mem_req_o, 32'd0);
            chk("wait_valid", valid_o,   32'd0);
            for (int i = 0; i < rvd; i++) begin
               step();
               chk("wait_valid", valid_o, 32'd0);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word;
            step();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
         end
      end else begin
         chk("no_req", mem_req_o, 32'd0);
      end
      chk("valid",  valid_o,  32'd1);
      chk("result", result_o, e.result);
      chk("fault",  fault_o,  32'(e.fault));
      chk("rd",     rd_o,     32'(rdv));
      chk("done_ready", ready_o, 32'd0);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold", 32'(valid_o && !ready_o && !mem_req_o && result_o == e.result
                         && fault_o == e.fault && rd_o == rdv), 32'd1);
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk("wb_valid_drop", valid_o, 32'd0);
      chk("wb_ready_back", ready_o, 32'd1);
   endtask

   initial begin
      logic [6:0]  r_op;
      logic [31:0] r_addr;
      valid_i      = 1'b0;
      opcode_i     = '0;
      funct3_i     = '0;
      addr_i       = '0;
      store_data_i = '0;
      rd_i         = '0;
      ready_i      = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      reset_n      = 1'b1;
      #2 reset_n   = 1'b0;
      step();
      step();
      chk_reset_vals("rst");
      reset_n = 1'b1;
      step();

      // LW aligned, fastest memory: valid three cycles after accept
      run_op(OP_LOAD, 3'd2, 32'h0000_1000, 32'h0, 5'd1, 0, 0, 32'hDEAD_BEEF, 0, 1'b0);
      // LB/LBU top byte with sign bit set
      run_op(OP_LOAD, 3'd0, 32'h0000_1003, 32'h0, 5'd2, 0, 0, 32'h80FF_1234, 0, 1'b1);
      run_op(OP_LOAD, 3'd4, 32'h0000_1003, 32'h0, 5'd3, 1, 2, 32'h80FF_1234, 1, 1'b0);
      // LH/LHU upper half
      run_op(OP_LOAD, 3'd1, 32'h0000_1002, 32'h0, 5'd4, 0, 1, 32'h9ABC_1234, 0, 1'b0);
      run_op(OP_LOAD, 3'd5, 32'h0000_1002, 32'h0, 5'd5, 0, 1, 32'h9ABC_1234, 0, 1'b0);
      // SH upper half with grant delayed three cycles
      run_op(OP_STORE, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 5'd6, 3, 0, 32'h0, 0, 1'b0);
      run_op(OP_STORE, 3'd0, 32'h0000_2001, 32'h1234_5677, 5'd7, 0, 0, 32'h0, 0, 1'b0);
      run_op(OP_STORE, 3'd2, 32'h0000_2004, 32'hCAFE_F00D, 5'd8, 1, 0, 32'h0, 0, 1'b0);
      // faults: misaligned LW, misaligned SH, illegal load and store funct3
      run_op(OP_LOAD,  3'd2, 32'h0000_1002, 32'h0, 5'd9,  0, 0, 32'h0, 0, 1'b0);
      run_op(OP_STORE, 3'd1, 32'h0000_2001, 32'hFFFF_FFFF, 5'd10, 0, 0, 32'h0, 0, 1'b0);
      run_op(OP_LOAD,  3'd3, 32'h0000_1000, 32'h0, 5'd11, 0, 0, 32'h0, 0, 1'b0);
      run_op(OP_STORE, 3'd4, 32'h0000_2000, 32'h0, 5'd12, 0, 0, 32'h0, 0, 1'b0);
      // ALU pass-through with writeback stalled four cycles
      run_op(OP_ALU, 3'd0, 32'h0000_0042, 32'h0, 5'd13, 0, 0, 32'h0, 4, 1'b0);

      // reset asserted while waiting for load data; a late rvalid must be ignored
      valid_i  = 1'b1;
      opcode_i = OP_LOAD;
      funct3_i = 3'd2;
      addr_i   = 32'h0000_3000;
      rd_i     = 5'd14;
      step();
      valid_i   = 1'b0;
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk_reset_vals("rst_wait");
      step();
      reset_n      = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1111_2222;
      step();
      mem_rvalid_i = 1'b0;
      chk_reset_vals("late_rvalid");

      // reset while requesting: mem_req_o falls without a clock edge
      valid_i  = 1'b1;
      opcode_i = OP_STORE;
      funct3_i = 3'd2;
      addr_i   = 32'h0000_4000;
      step();
      valid_i = 1'b0;
      chk("req_before_rst", mem_req_o, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("req_async_drop", mem_req_o, 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // random operations against the model
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0:       r_op = OP_LOAD;
            1:       r_op = OP_STORE;
            2:       r_op = OP_ALU;
            default: r_op = 7'($urandom);
         endcase
         r_addr = $urandom;
         if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
         run_op(r_op, 3'($urandom_range(0, 7)), r_addr, $urandom, 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                $urandom_range(0, 2), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
